// File: rtl/spi_defs.sv
// Shared SPI definitions used by both the SPI master and the SPI slave.
//   - rco status bit positions
//   - SPI mode encoding {cpol,cpha}
//   - frame width and the bit counter sized to it
package spi_defs;

  localparam int RCO_BUSY = 0;
  localparam int RCO_DONE = 1;
  localparam int RCO_OVR  = 2;

  localparam int FRAME_W = 8;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_W - 1);

  typedef enum logic [1:0] {
    SPI_MODE0 = 2'b00,
    SPI_MODE1 = 2'b01,
    SPI_MODE2 = 2'b10,
    SPI_MODE3 = 2'b11
  } spi_mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_slv_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for one asynchronous pin, with rise/fall pulses
// derived from the synchronized value.
//   clk, rst  : core clock, synchronous active-high reset
//   d         : asynchronous input pin
//   q         : synchronized level
//   rise/fall : one-cycle pulses when q changes
module spi_sync_edge #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [N-1:0] sync_q, sync_d;
  logic         prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[N-2:0], d};
    prev_d = sync_q[N-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {N{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[N-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave: oversamples sck/ss/mosi on clk, assembles 8-bit frames and
// drives miso from a core-loaded transmit buffer. All four CPOL/CPHA modes,
// MSB- or LSB-first.
//   turnon           : 0 holds the block idle and clears state/flags
//   cpol/cpha/order  : SPI mode, order 1 = LSB first
//   din/load         : load strobe captures din[7:0] into tx_buf
//   rd               : core read strobe, clears done/ovr
//   sck/ss/mosi/miso : SPI pins
//   rco              : {29'h0, ovr, done, busy}
//   dat              : {24'h0, rx}
module spi_slave
  import spi_defs::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        turnon,
  input  logic        cpol,
  input  logic        cpha,
  input  logic        order,
  input  logic [31:0] din,
  input  logic        load,
  input  logic        rd,
  input  logic        sck,
  input  logic        ss,
  input  logic        mosi,
  output logic        miso,
  output logic [31:0] rco,
  output logic [31:0] dat
);

  logic sck_s, sck_rise, sck_fall;
  logic ss_s, ss_unused_rise, ss_fall;
  logic mosi_s, mosi_unused_rise, mosi_unused_fall;
  logic [23:0] din_unused;
  assign din_unused = din[31:8];

  spi_sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk(clk), .rst(rst), .d(sck), .q(sck_s), .rise(sck_rise), .fall(sck_fall));
  spi_sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
    .clk(clk), .rst(rst), .d(ss), .q(ss_s), .rise(ss_unused_rise), .fall(ss_fall));
  spi_sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .d(mosi), .q(mosi_s), .rise(mosi_unused_rise),
    .fall(mosi_unused_fall));

  spi_slv_state_e   state_q, state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d, p_q, p_d, rx_idx;
  logic [FRAME_W-1:0] rx_shift_q, rx_shift_d, rx_q, rx_d;
  logic [FRAME_W-1:0] tx_buf_q, tx_buf_d, tx_cur_q, tx_cur_d;
  logic done_q, done_d, ovr_q, ovr_d;
  logic lead, trail, samp, shft;

  // Leading edge leaves the idle level cpol, trailing edge returns to it.
  assign lead  = cpol ? sck_fall : sck_rise;
  assign trail = cpol ? sck_rise : sck_fall;
  assign samp  = cpha ? trail : lead;
  assign shft  = cpha ? lead  : trail;
  assign rx_idx = order ? rx_cnt_q : CNT_MAX - rx_cnt_q;

  always_comb begin
    state_d    = state_q;
    rx_cnt_d   = rx_cnt_q;
    p_d        = p_q;
    rx_shift_d = rx_shift_q;
    rx_d       = rx_q;
    tx_buf_d   = load ? din[FRAME_W-1:0] : tx_buf_q;
    tx_cur_d   = tx_cur_q;
    done_d     = done_q;
    ovr_d      = ovr_q;

    if (rd) begin
      done_d = 1'b0;
      ovr_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (ss_fall && turnon) begin
          state_d  = ST_ACTIVE;
          rx_cnt_d = '0;
          p_d      = '0;
          tx_cur_d = tx_buf_q;
        end
      end
      ST_ACTIVE: begin
        if (ss_s) begin
          // Partial byte is dropped; done stays as it was.
          state_d  = ST_IDLE;
          rx_cnt_d = '0;
        end else if (samp) begin
          rx_shift_d[rx_idx] = mosi_s;
          rx_cnt_d = rx_cnt_q + 1'b1;
          if (rx_cnt_q == CNT_MAX) begin
            rx_d   = rx_shift_d;
            done_d = 1'b1;
            // A read landing on the completion cycle leaves ovr untouched.
            ovr_d  = (done_q && !rd) ? 1'b1 : ovr_q;
          end
        end else if (shft) begin
          p_d = rx_cnt_q;
          if (rx_cnt_q == '0) tx_cur_d = tx_buf_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!turnon) begin
      state_d  = ST_IDLE;
      rx_cnt_d = '0;
      p_d      = '0;
      done_d   = 1'b0;
      ovr_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rx_cnt_q   <= '0;
      p_q        <= '0;
      rx_shift_q <= '0;
      rx_q       <= '0;
      tx_buf_q   <= 8'hFF;
      tx_cur_q   <= 8'hFF;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_cnt_q   <= rx_cnt_d;
      p_q        <= p_d;
      rx_shift_q <= rx_shift_d;
      rx_q       <= rx_d;
      tx_buf_q   <= tx_buf_d;
      tx_cur_q   <= tx_cur_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
    end
  end

  always_comb begin
    miso = 1'b1;
    if (state_q == ST_ACTIVE) miso = tx_cur_q[order ? p_q : CNT_MAX - p_q];
    rco = '0;
    rco[RCO_BUSY] = (state_q == ST_ACTIVE);
    rco[RCO_DONE] = done_q;
    rco[RCO_OVR]  = ovr_q;
    dat = {24'h0, rx_q};
  end

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;
  localparam int SYNC = 2;
  localparam int H    = SYNC + 4;

  logic clk = 0, rst = 1, turnon = 0, cpol = 0, cpha = 0, order = 0;
  logic [31:0] din = 0;
  logic load = 0, rd = 0, sck = 0, ss = 1, mosi = 0;
  logic miso;
  logic [31:0] rco, dat;

  spi_slave #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .turnon(turnon), .cpol(cpol), .cpha(cpha),
    .order(order), .din(din), .load(load), .rd(rd), .sck(sck), .ss(ss),
    .mosi(mosi), .miso(miso), .rco(rco), .dat(dat));

  always #10 clk = ~clk;

  int n_vec = 0, n_err = 0;

  // reference model state
  logic [7:0] m_txbuf = 8'hFF, m_rx = 8'h00;
  logic       m_done = 0, m_ovr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic half(input bit do_rd, input bit do_ld, input logic [7:0] ld_val);
    for (int k = 0; k < H; k++) begin
      rd   = do_rd && (k == SYNC);
      load = do_ld && (k == 0);
      din  = {$urandom_range(0, 255) > 0 ? 24'hABCDEF : 24'h0, ld_val};
      tick(1);
    end
    rd = 0; load = 0;
  endtask

  function automatic logic [31:0] exp_rco(input bit busy);
    return {29'h0, m_ovr, m_done, busy};
  endfunction

  task automatic set_mode(input bit pol, input bit pha, input bit ord);
    cpol = pol; cpha = pha; order = ord; sck = pol;
    tick(8);
  endtask

  task automatic load_pulse(input logic [7:0] v);
    din = {24'h123456, v}; load = 1; tick(1); load = 0;
    m_txbuf = v;
  endtask

  task automatic rd_pulse();
    rd = 1; tick(1); rd = 0;
    m_done = 0; m_ovr = 0;
  endtask

  task automatic ss_assert();
    ss = 0; tick(8);
  endtask

  task automatic ss_release();
    tick(H); ss = 1; tick(6);
  endtask

  // Master side of one byte (or the first nbits of it). Optionally loads the
  // slave tx buffer during bit 3 and/or strobes rd on the cycle the slave
  // registers the final sample edge.
  task automatic xfer(input logic [7:0] mo, input int nbits, input bit ld_mid,
                      input logic [7:0] ld_val, input bit rd_end,
                      output logic [7:0] mi);
    int idx;
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      idx = order ? i : 7 - i;
      if (!cpha) begin
        mosi = mo[idx];
        half(0, ld_mid && i == 3, ld_val);
        sck = ~cpol; mi[idx] = miso;
        half(rd_end && i == 7, 0, ld_val);
        sck = cpol;
      end else begin
        sck = ~cpol; mosi = mo[idx];
        half(0, ld_mid && i == 3, ld_val);
        sck = cpol; mi[idx] = miso;
        half(rd_end && i == 7, 0, ld_val);
      end
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input bit rd_end);
    if (m_done && !rd_end) m_ovr = 1;
    m_done = 1;
    m_rx = b;
  endtask

  // One full-byte transfer inside an asserted frame, checked against the model.
  task automatic byte_chk(input string tag, input logic [7:0] mo, input bit ld_mid,
                          input logic [7:0] ld_val, input bit rd_end);
    logic [7:0] mi, exp_tx;
    exp_tx = m_txbuf;
    xfer(mo, 8, ld_mid, ld_val, rd_end, mi);
    chk({tag, "_miso"}, {24'h0, mi}, {24'h0, exp_tx});
    if (ld_mid) m_txbuf = ld_val;
    model_byte(mo, rd_end);
  endtask

  initial begin
    logic [7:0] mi, v;
    int nb;
    bit partial;

    tick(3);
    chk("rst_rco", rco, 32'h0);
    chk("rst_dat", dat, 32'h0);
    chk("rst_miso", {31'h0, miso}, 32'h1);
    rst = 0; turnon = 1; tick(2);

    // mode 0, MSB first
    set_mode(0, 0, 0);
    load_pulse(8'hA5);
    ss_assert();
    chk("t1_busy", rco, exp_rco(1));
    byte_chk("t1", 8'h3C, 0, 8'h00, 0);
    ss_release();
    chk("t1_dat", dat, 32'h3C);
    chk("t1_rco", rco, 32'h2);
    rd_pulse();

    // mode 3, LSB first
    set_mode(1, 1, 1);
    load_pulse(8'h81);
    chk("t2_idle", rco, 32'h0);
    ss_assert();
    chk("t2_busy", rco, 32'h1);
    byte_chk("t2", 8'h96, 0, 8'h00, 0);
    chk("t2_busy_end", rco[0], 1);
    ss_release();
    chk("t2_dat", dat, 32'h96);
    chk("t2_rco", rco, 32'h2);
    rd_pulse();

    // back-to-back bytes, mid-byte load, overrun
    set_mode(0, 0, 0);
    load_pulse(8'h11);
    ss_assert();
    byte_chk("t3a", 8'h11, 1, 8'h55, 0);
    byte_chk("t3b", 8'h22, 0, 8'h00, 0);
    ss_release();
    chk("t3_dat", dat, 32'h22);
    chk("t3_rco", rco, 32'h6);
    rd_pulse(); tick(1);
    chk("t3_rd", rco, 32'h0);

    // partial frame then full frame
    set_mode(0, 1, 0);
    ss_assert();
    xfer(8'h0F, 5, 0, 8'h00, 0, mi);
    ss_release();
    chk("t4_partial", rco, 32'h0);
    ss_assert();
    byte_chk("t4", 8'hF0, 0, 8'h00, 0);
    ss_release();
    chk("t4_dat", dat, 32'hF0);
    chk("t4_rco", rco, 32'h2);

    // rd coincident with completion while done already set
    set_mode(1, 0, 1);
    ss_assert();
    byte_chk("t5", 8'h6B, 0, 8'h00, 1);
    ss_release();
    chk("t5_dat", dat, 32'h6B);
    chk("t5_rco", rco, 32'h2);

    // turnon=0 clears flags, keeps rx
    turnon = 0; tick(2);
    m_done = 0; m_ovr = 0;
    chk("t6_off_rco", rco, 32'h0);
    chk("t6_off_dat", dat, {24'h0, m_rx});
    turnon = 1; tick(2);

    // reset mid-frame, then mode-1 frame
    set_mode(0, 0, 0);
    load_pulse(8'h3E);
    ss_assert();
    xfer(8'hC3, 3, 0, 8'h00, 0, mi);
    rst = 1; tick(1);
    chk("t7_miso", {31'h0, miso}, 32'h1);
    chk("t7_rco", rco, 32'h0);
    chk("t7_dat", dat, 32'h0);
    rst = 0;
    m_txbuf = 8'hFF; m_rx = 8'h00; m_done = 0; m_ovr = 0;
    ss_release();
    set_mode(0, 1, 0);
    ss_assert();
    byte_chk("t7", 8'h5A, 0, 8'h00, 0);
    ss_release();
    chk("t7_dat2", dat, 32'h5A);
    chk("t7_rco2", rco, 32'h2);

    // randomized frames
    for (int it = 0; it < 24; it++) begin
      set_mode($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      if ($urandom_range(0, 1)) load_pulse(8'($urandom));
      if ($urandom_range(0, 2) == 0) rd_pulse();
      partial = ($urandom_range(0, 4) == 0);
      nb = $urandom_range(1, 2);
      ss_assert();
      chk("r_busy", rco, exp_rco(1));
      if (partial) begin
        xfer(8'($urandom), $urandom_range(1, 7), 0, 8'h00, 0, mi);
      end else begin
        for (int b = 0; b < nb; b++) begin
          v = 8'($urandom);
          byte_chk("r", 8'($urandom), $urandom_range(0, 1), v,
                   (b == nb - 1) && ($urandom_range(0, 3) == 0));
        end
      end
      ss_release();
      chk("r_dat", dat, {24'h0, m_rx});
      chk("r_rco", rco, exp_rco(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
